// File: rtl/blink_pattern_detector.sv
// Checks a serial blink line for BURSTS bursts of ON_LEN high / OFF_LEN low samples.
// Emits a one-cycle detected or error pulse; err_code holds the cause of the last error.
module blink_pattern_detector #(
  parameter int unsigned ON_LEN  = 6,
  parameter int unsigned OFF_LEN = 4,
  parameter int unsigned BURSTS  = 3,
  parameter int unsigned TOL     = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             din,
  output logic                             busy,
  output logic                             detected,
  output logic                             error,
  output logic [1:0]                       err_code,
  output logic [$clog2(BURSTS + 1) - 1:0]  burst_idx
);

  localparam int unsigned CntMax = ((ON_LEN > OFF_LEN) ? ON_LEN : OFF_LEN) + TOL + 1;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned BurstW = $clog2(BURSTS + 1);

  typedef logic [CntW-1:0]   cnt_t;
  typedef logic [BurstW-1:0] burst_t;

  localparam cnt_t   OnMax     = cnt_t'(ON_LEN + TOL);
  localparam cnt_t   OnMin     = cnt_t'(ON_LEN - TOL);
  localparam cnt_t   OffMax    = cnt_t'(OFF_LEN + TOL);
  localparam cnt_t   OffMin    = cnt_t'(OFF_LEN - TOL);
  localparam cnt_t   OffExact  = cnt_t'(OFF_LEN);
  localparam cnt_t   CntSat    = cnt_t'(CntMax);
  localparam burst_t LastBurst = burst_t'(BURSTS);

  localparam logic [1:0] ErrHighShort = 2'd1;
  localparam logic [1:0] ErrHighLong  = 2'd2;
  localparam logic [1:0] ErrLowLen    = 2'd3;

  typedef enum logic [1:0] {StIdle, StOn, StOff, StRecover} state_e;

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d, cnt_inc;
  burst_t     burst_q, burst_d;
  logic       detected_q, detected_d;
  logic       error_q, error_d;
  logic [1:0] err_code_q, err_code_d;
  logic       busy_q, busy_d;
  burst_t     burst_idx_q, burst_idx_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      burst_q     <= '0;
      detected_q  <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
      busy_q      <= 1'b0;
      burst_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      burst_q     <= burst_d;
      detected_q  <= detected_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
      burst_idx_q <= burst_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    burst_d    = burst_q;
    detected_d = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    cnt_inc    = (cnt_q == CntSat) ? cnt_q : cnt_q + cnt_t'(1);

    unique case (state_q)
      StIdle: begin
        if (din) begin
          state_d = StOn;
          cnt_d   = cnt_t'(1);
          burst_d = burst_t'(1);
        end
      end
      StOn: begin
        if (din) begin
          if (cnt_inc > OnMax) begin
            error_d    = 1'b1;
            err_code_d = ErrHighLong;
            state_d    = StRecover;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (cnt_q < OnMin) begin
          error_d    = 1'b1;
          err_code_d = ErrHighShort;
          state_d    = StRecover;
        end else begin
          state_d = StOff;
          cnt_d   = cnt_t'(1);
        end
      end
      StOff: begin
        if (burst_q == LastBurst) begin
          // Final low run must be exact: no tolerance, detection on the last low sample.
          if (din) begin
            error_d    = 1'b1;
            err_code_d = ErrLowLen;
            state_d    = StRecover;
          end else if (cnt_inc == OffExact) begin
            detected_d = 1'b1;
            state_d    = StIdle;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!din) begin
          if (cnt_inc > OffMax) begin
            // Line is already low, so no recovery wait is needed.
            error_d    = 1'b1;
            err_code_d = ErrLowLen;
            state_d    = StIdle;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (cnt_q >= OffMin && cnt_q <= OffMax) begin
          state_d = StOn;
          cnt_d   = cnt_t'(1);
          burst_d = burst_q + burst_t'(1);
        end else begin
          error_d    = 1'b1;
          err_code_d = ErrLowLen;
          state_d    = StRecover;
        end
      end
      StRecover: begin
        if (!din) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle || state_d == StRecover) begin
      cnt_d   = '0;
      burst_d = '0;
    end
  end

  always_comb begin
    busy_d      = (state_d == StOn) || (state_d == StOff);
    burst_idx_d = busy_d ? burst_d : '0;
  end

  assign busy      = busy_q;
  assign detected  = detected_q;
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign burst_idx = burst_idx_q;

endmodule
